// File: rtl/tx_seq_ctrl.sv
// tx_seq_ctrl: single-clock sequencer for the QPSK transmit chain.
// A single sample-rate clock drives the whole chain. This block generates the
// enable strobes for the PRBS source and the tx pulse-shaping filter. It also
// owns run/stop control, the polyphase index, the zero-fill drain and the
// decimation strobe.
//
// Handshake: there is no valid/ready pair. i_start and i_stop are level
// requests sampled on every rising edge. i_start is acted on only in IDLE and
// i_stop only in RUN; the request is ignored in every other state. Every
// output strobe is exactly one clock wide and is registered.
//
// Timing: outputs are decoded from the next state and next phase count, then
// registered. In any cycle the outputs therefore describe that cycle's
// state/phase exactly. o_sym_count counts completed o_prbs_en pulses. It
// clears on the start edge and steps on the edge that ends each pulse.
module tx_seq_ctrl #(
  parameter int OS        = 4,   // samples per symbol, power of two, >= 2
  parameter int DRAIN_SYM = 6,   // zero symbols pushed through the filter on stop
  parameter int CNT_W     = 16,  // symbol counter width
  localparam int PH_W     = (OS > 1) ? $clog2(OS) : 1,
  localparam int DR_W     = $clog2(DRAIN_SYM + 1)
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active low
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [PH_W-1:0]  i_phase_sel,
  output logic             o_prbs_en,
  output logic             o_sym_en,
  output logic             o_tx_en,
  output logic             o_zero_fill,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_rx_strobe,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_sym_count,
  output logic [1:0]       o_state       // debug: current FSM state encoding
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_SYM);

  state_t            state;
  state_t            state_n;
  logic [PH_W-1:0]   cnt;
  logic [PH_W-1:0]   cnt_n;
  logic              stop_pending;
  logic              stop_pending_n;
  logic [DR_W-1:0]   drain_cnt;
  logic [DR_W-1:0]   drain_cnt_n;
  logic [CNT_W-1:0]  sym_count_n;

  logic              prbs_en_n;
  logic              sym_en_n;
  logic              tx_en_n;
  logic              zero_fill_n;
  logic [PH_W-1:0]   phase_n;
  logic              rx_strobe_n;
  logic              busy_n;

  // Next-state logic: start/stop acceptance, phase wrap and drain length.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    stop_pending_n = stop_pending;
    drain_cnt_n    = drain_cnt;
    sym_count_n    = o_sym_count;

    // Count each completed PRBS pulse, holding at all-ones.
    if (o_prbs_en && (o_sym_count != {CNT_W{1'b1}})) begin
      sym_count_n = o_sym_count + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        // Start wins over a simultaneous stop; stop is meaningless here.
        if (i_start) begin
          state_n        = RUN;
          cnt_n          = '0;
          stop_pending_n = 1'b0;
          sym_count_n    = '0;
        end
      end

      RUN: begin
        cnt_n = cnt + PH_W'(1);
        if (i_stop) begin
          stop_pending_n = 1'b1;
        end
        // Stop is deferred to the symbol boundary so the symbol in flight
        // still gets all OS samples.
        if ((cnt == PH_LAST) && (stop_pending || i_stop)) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end
      end

      DRAIN: begin
        cnt_n = cnt + PH_W'(1);
        if (cnt == '0) begin
          drain_cnt_n = drain_cnt + DR_W'(1);
        end
        // Leave on the last sample of the final zero symbol.
        if ((cnt == PH_LAST) && (drain_cnt == DR_LAST)) begin
          state_n        = IDLE;
          cnt_n          = '0;
          stop_pending_n = 1'b0;
          drain_cnt_n    = '0;
        end
      end

      default: begin
        state_n        = IDLE;
        cnt_n          = '0;
        stop_pending_n = 1'b0;
        drain_cnt_n    = '0;
      end
    endcase
  end

  // Output decode from the next state/phase so the registered outputs line up
  // with the cycle they describe.
  always_comb begin
    busy_n      = (state_n != IDLE);
    tx_en_n     = busy_n;
    phase_n     = busy_n ? cnt_n : '0;
    sym_en_n    = busy_n && (cnt_n == '0);
    prbs_en_n   = (state_n == RUN) && (cnt_n == '0);
    zero_fill_n = (state_n == DRAIN);
    rx_strobe_n = busy_n && (cnt_n == i_phase_sel);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stop_pending <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      stop_pending <= stop_pending_n;
      drain_cnt    <= drain_cnt_n;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_prbs_en   <= 1'b0;
      o_sym_en    <= 1'b0;
      o_tx_en     <= 1'b0;
      o_zero_fill <= 1'b0;
      o_phase     <= '0;
      o_rx_strobe <= 1'b0;
      o_busy      <= 1'b0;
      o_sym_count <= '0;
    end else begin
      o_prbs_en   <= prbs_en_n;
      o_sym_en    <= sym_en_n;
      o_tx_en     <= tx_en_n;
      o_zero_fill <= zero_fill_n;
      o_phase     <= phase_n;
      o_rx_strobe <= rx_strobe_n;
      o_busy      <= busy_n;
      o_sym_count <= sym_count_n;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Testbench for tx_seq_ctrl (OS=4, DRAIN_SYM=6, CNT_W=16) plus a narrow
// CNT_W=2 instance that exercises symbol counter saturation.
module tb_tx_seq_ctrl;

  localparam int SB_W = 22;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_phase_sel;

  always #5 clk = ~clk;

  logic        o_prbs_en, o_sym_en, o_tx_en, o_zero_fill, o_rx_strobe, o_busy;
  logic [1:0]  o_phase, o_state;
  logic [15:0] o_sym_count;

  logic        s_prbs_en, s_sym_en, s_tx_en, s_zero_fill, s_rx_strobe, s_busy;
  logic [1:0]  s_phase, s_state, s_sym_count;

  tx_seq_ctrl #(.OS(4), .DRAIN_SYM(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_phase_sel(i_phase_sel), .o_prbs_en(o_prbs_en), .o_sym_en(o_sym_en),
    .o_tx_en(o_tx_en), .o_zero_fill(o_zero_fill), .o_phase(o_phase),
    .o_rx_strobe(o_rx_strobe), .o_busy(o_busy), .o_sym_count(o_sym_count),
    .o_state(o_state)
  );

  tx_seq_ctrl #(.OS(4), .DRAIN_SYM(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_phase_sel(i_phase_sel), .o_prbs_en(s_prbs_en), .o_sym_en(s_sym_en),
    .o_tx_en(s_tx_en), .o_zero_fill(s_zero_fill), .o_phase(s_phase),
    .o_rx_strobe(s_rx_strobe), .o_busy(s_busy), .o_sym_count(s_sym_count),
    .o_state(s_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int prbs_total = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected record for one symbol-load cycle: phase 0, tx and busy high.
  task automatic push_exp(input bit prbs, input bit zf, input int cnt);
    logic [15:0] c;
    c = cnt[15:0];
    exp_q.push_back({2'd0, prbs, zf, 1'b1, 1'b1, c});
  endtask

  // Monitor: every symbol-load strobe consumes one expected record.
  always @(negedge clk) begin
    if (o_prbs_en) prbs_total++;
    if (o_sym_en) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_sym", 32'(o_sym_count), 32'hFFFF_FFFF);
      end else begin
        check("sb_sym", 32'({o_phase, o_prbs_en, o_zero_fill, o_tx_en, o_busy, o_sym_count}),
              32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full per-cycle output check against the hand-computed cycle description.
  task automatic exp_cycle(input string tag, input int ph, input bit run,
                           input bit drain, input bit rx, input int cnt);
    logic       busy;
    logic [1:0] p;
    logic [1:0] st;
    logic [9:0] e;
    busy = run | drain;
    p    = ph[1:0];
    st   = drain ? 2'd2 : (run ? 2'd1 : 2'd0);
    e    = {p, run && (p == 2'd0), busy && (p == 2'd0), drain, busy, busy, rx, st};
    check({tag, "_ctl"}, 32'({o_phase, o_prbs_en, o_sym_en, o_zero_fill, o_tx_en,
                               o_busy, o_rx_strobe, o_state}), 32'(e));
    check({tag, "_count"}, 32'(o_sym_count), cnt);
  endtask

  int drain_pulses;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_phase_sel = 2'd2;

    // 1. reset then idle
    repeat (3) begin tick(); exp_cycle("reset", 0, 0, 0, 0, 0); end
    rst = 1'b1;
    repeat (10) begin tick(); exp_cycle("idle", 0, 0, 0, 0, 0); end

    // 2/4. start, run 40 cycles with rx strobe on phase 2
    for (int i = 0; i < 12; i++) push_exp(1'b1, 1'b0, i);
    for (int i = 0; i < 6; i++) push_exp(1'b0, 1'b1, 12);
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp_cycle("run", k % 4, 1, 0, (k % 4) == 2, (k + 3) / 4);
      if (k == 20)
        check("sat_instance", 32'({s_phase, s_prbs_en, s_sym_en, s_zero_fill, s_tx_en,
                                   s_busy, s_rx_strobe, s_state, s_sym_count}),
              32'({2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3}));
      tick();
    end
    check("count_after_40", 32'(o_sym_count), 10);

    // 4/5. move rx strobe to phase 0; start during RUN is ignored
    i_phase_sel = 2'd0; i_start = 1'b1;
    for (int k = 40; k < 45; k++) begin
      exp_cycle("rx_switch", k % 4, 1, 0, (k > 40) && ((k % 4) == 0), (k + 3) / 4);
      tick();
    end
    i_start = 1'b0;

    // 3. stop at phase 1: two more RUN cycles, then 24 DRAIN cycles
    exp_cycle("pre_stop", 1, 1, 0, 0, 12);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    exp_cycle("tail_run2", 2, 1, 0, 0, 12); tick();
    exp_cycle("tail_run3", 3, 1, 0, 0, 12); tick();
    drain_pulses = 0;
    for (int d = 0; d < 24; d++) begin
      exp_cycle("drain", d % 4, 0, 1, (d % 4) == 0, 12);
      if (o_sym_en) drain_pulses++;
      if (d == 5) begin i_start = 1'b1; i_stop = 1'b1; end
      if (d == 6) begin i_start = 1'b0; i_stop = 1'b0; end
      tick();
    end
    check("drain_sym_pulses", 32'(drain_pulses), 6);

    // 5. stop in IDLE is ignored; count holds
    i_stop = 1'b1;
    repeat (3) begin exp_cycle("idle_hold", 0, 0, 0, 0, 12); tick(); end
    i_stop = 1'b0;

    // 5. start+stop together: RUN without a pending stop; then stop lands on
    //    the phase-3 cycle itself and drains from the next cycle
    push_exp(1'b1, 1'b0, 0); push_exp(1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, 2);
    i_start = 1'b1; i_stop = 1'b1; tick(); i_start = 1'b0; i_stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_cycle("both", k % 4, 1, 0, (k % 4) == 0, (k + 3) / 4);
      if (k == 7) i_stop = 1'b1;
      tick();
    end
    i_stop = 1'b0;
    for (int d = 0; d < 10; d++) begin
      exp_cycle("drain2", d % 4, 0, 1, (d % 4) == 0, 2);
      tick();
    end

    // 6. async reset mid-DRAIN, between edges
    #3; rst = 1'b0; #1;
    exp_cycle("async_rst", 0, 0, 0, 0, 0);
    check("prbs_before_restart", 32'(prbs_total), 14);
    tick(); exp_cycle("in_rst", 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); exp_cycle("post_rst_idle", 0, 0, 0, 0, 0);

    push_exp(1'b1, 1'b0, 0); push_exp(1'b1, 1'b0, 1);
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_cycle("restart", k % 4, 1, 0, (k % 4) == 0, (k + 3) / 4);
      if (k == 1) check("prbs_resume", 32'(prbs_total), 15);
      tick();
    end

    rst = 1'b0; tick();
    exp_cycle("final_rst", 0, 0, 0, 0, 0);
    check("sb_all_consumed", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_seq_ctrl.md
Name: tx_seq_ctrl

Overview:
- Single-clock sequencer for the QPSK transmit chain: PRBS source → tx pulse-shaping filter.
- Replaces the separate symbol/sample clocks with one sample-rate clock plus enable strobes.
- Owns run/stop control: symbol strobes, filter phase index, a zero-fill drain so the filter output settles to zero, and a decimation strobe for downstream samplers.

Parameters:
- OS, 4, oversampling factor (samples per symbol); power of two, ≥2.
- DRAIN_SYM, 6, zero symbols fed to the filter after stop (filter taps / OS).
- CNT_W, 16, width of the symbol counter.

Ports:
- clk  in  1  sample-rate clock.
- rst  in  1  asynchronous active-low reset.
- i_start  in  1  start request; level-sampled, honoured only in IDLE.
- i_stop  in  1  stop request; level-sampled, honoured only in RUN.
- i_phase_sel  in  log2(OS)  phase at which o_rx_strobe fires.
- o_prbs_en  out  1  PRBS advance enable, 1 clk wide.
- o_sym_en  out  1  filter symbol-load strobe, 1 clk wide.
- o_tx_en  out  1  filter sample enable.
- o_zero_fill  out  1  filter input forced to zero.
- o_phase  out  log2(OS)  current polyphase index.
- o_rx_strobe  out  1  decimation strobe.
- o_busy  out  1  state ≠ IDLE.
- o_sym_count  out  CNT_W  PRBS symbols emitted since the last start; saturates at all-ones.

Behaviour:
- All outputs are registered. On rst=0 (async): state=IDLE, phase counter=0, stop_pending=0, drain counter=0, and every output=0, including o_sym_count.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Outputs 0; o_sym_count holds its last value.
  - i_start=1 → RUN on the next edge. In that same edge o_sym_count clears to 0 and cnt loads 0.
  - i_stop is ignored; start wins if both are high.
- RUN (k=0 is the first RUN cycle):
  - cnt = k mod OS; o_phase = cnt; o_tx_en = 1.
  - o_sym_en = o_prbs_en = (cnt==0); o_zero_fill = 0.
  - o_sym_count increments on each o_prbs_en cycle and saturates.
  - i_stop=1 sets stop_pending. i_start is ignored.
  - When cnt==OS-1 and stop_pending (set this cycle or earlier) → DRAIN. Stop therefore always lands on a symbol boundary, and the symbol in progress completes all OS samples.
- DRAIN:
  - cnt continues to wrap; o_tx_en = 1; o_zero_fill = 1; o_sym_en = (cnt==0); o_prbs_en = 0.
  - The drain counter counts o_sym_en pulses. After DRAIN_SYM symbols, at cnt==OS-1 of the last symbol → IDLE; stop_pending and cnt clear.
  - i_start and i_stop are ignored. Total DRAIN length is exactly DRAIN_SYM·OS cycles.
- o_rx_strobe = (cnt==i_phase_sel) in RUN and DRAIN, 0 in IDLE. i_phase_sel is sampled every cycle; a change takes effect on the next cycle.
- PRBS stall: o_prbs_en is low in DRAIN, so the PRBS state is frozen. A restart resumes the sequence with no reseed.
- Reset asserted mid-RUN or mid-DRAIN: immediate return to IDLE with all outputs 0; no drain is performed.
- Counter wrap: cnt is log2(OS) bits and wraps naturally. The drain counter width is clog2(DRAIN_SYM+1).

Test Plan (OS=4, DRAIN_SYM=6, CNT_W=16):
1. Reset then idle:
   - Stimulus: hold rst=0 for 3 clk, release, no start for 10 clk.
   - Required: every output 0 throughout; o_busy=0.
2. Start and run:
   - Stimulus: pulse i_start for 1 clk, run 40 clk.
   - Required: o_tx_en=1 from the next cycle; o_phase sequence 0,1,2,3,0…; o_prbs_en/o_sym_en high on phase 0 only (10 pulses); o_sym_count=10.
3. Stop mid-symbol:
   - Stimulus: assert i_stop while o_phase=1.
   - Required: 2 more RUN cycles; then 24 DRAIN cycles with o_zero_fill=1, o_prbs_en=0, 6 o_sym_en pulses; then IDLE with o_busy=0; o_sym_count unchanged.
4. Decimation strobe:
   - Stimulus: i_phase_sel=2 during RUN; then change to 0.
   - Required: o_rx_strobe coincides with o_phase=2; from the cycle after the change, it coincides with o_phase=0.
5. Ignored requests:
   - Stimulus: i_start during RUN and DRAIN; i_stop during IDLE; start and stop together in IDLE.
   - Required: no state disturbance; start+stop in IDLE enters RUN with stop_pending=0.
6. Async reset mid-DRAIN:
   - Stimulus: drop rst between clock edges.
   - Required: outputs 0 immediately. After release and i_start, o_sym_count restarts from 0 and the PRBS output continues its sequence without reseed.
